set_job_scheduler: RTL and testbench
====================================

// Module: set_job_scheduler
// PURPOSE
//  Shares one combinational point-in-circle checker between two job requesters.
//  Each job is a 3-circle set query over an 8x8 grid, with grid points (1..8, 1..8).
//  The block round-robin arbitrates the requesters, then steps through 64 points x 3 circles.
//  It drives the shared checker, counts the points that satisfy the selected set mode,
//  and returns the count tagged with the requester ID.
// PARAMETERS
//  GRID_LOG2  3  bits per grid axis; the grid is 2**GRID_LOG2 points square (fixed 8x8)
//  CNT_W      8  width of candidate; the internal count is GRID_LOG2*2+1 bits, zero-extended
// PORTS
//  clk            in   1   clock, rising-edge; the only clock
//  rst            in   1   asynchronous, active-high reset
//  reqN_valid     in   1   (N=0,1) requester N presents a job
//  reqN_ready     out  1   (N=0,1) job accepted this cycle when reqN_valid & reqN_ready
//  reqN_central   in   24  {xA,yA,xB,yB,xC,yC}, 4 bits each, xA in [23:20]
//  reqN_radius    in   12  {rA,rB,rC}, 4 bits each, rA in [11:8]
//  reqN_mode      in   2   0:A  1:A&B  2:A^B  3:exactly two of A,B,C
//  chk_x,chk_y,chk_r out 4 circle center and radius driven to the shared checker
//  chk_px,chk_py  out  4   grid point under test (1..8)
//  chk_in         in   1   checker result, same cycle: (x-px)^2+(y-py)^2 <= r^2
//  busy           out  1   job in progress
//  valid          out  1   one-cycle pulse; candidate and resp_id are valid
//  candidate      out  CNT_W  count of qualifying points (0..64)
//  resp_id        out  1   requester that owns the result
// BEHAVIOUR
//  - Reset values: busy=0, valid=0, candidate=0, resp_id=0, reqN_ready=0, chk_*=0.
//    Internal state: state=IDLE, count=0, last_id=1, so req0 wins the first tie.
//  - States: IDLE -> CHK -> DONE -> IDLE.
//  - IDLE:
//    - reqN_ready is combinational and asserts only for the granted requester.
//    - Only one valid: that requester is granted.
//    - Both valid: the requester != last_id is granted.
//    - On acceptance: latch central, radius and mode; set id and last_id to the granted N;
//      clear point=0, circ=0, count=0; go to CHK. Inputs are ignored after acceptance.
//  - CHK, one checker evaluation per cycle:
//    - circ 0/1/2 selects circle A/B/C on chk_x/chk_y/chk_r.
//    - chk_px = point[5:3]+1 and chk_py = point[2:0]+1.
//    - circ=0: A<=chk_in. circ=1: B<=chk_in.
//    - circ=2: count += f(mode,A,B,chk_in); circ wraps to 0 and point increments.
//    - After point 63, circ 2: go to DONE. CHK lasts exactly 192 cycles.
//  - DONE: valid=1, candidate=count (zero-extended), resp_id=id, for one cycle; then IDLE.
//  - busy is 1 from the cycle after acceptance through the DONE cycle.
//  - Latency: accept on edge T -> valid high in cycle T+193.
//    The next job can be accepted in the cycle after DONE.
//  - candidate holds its value until the next DONE or reset.
//  - chk_* outputs are 0 outside CHK.
//  - count never overflows (max 64 < 2**7); radius 0 matches only the center point.
//  - Centers outside 1..8 are legal; the checker decides the geometry.
//  - rst mid-job: immediate return to reset values; no valid for the aborted job.
//    Arbitration priority resets to req0.
// TESTING (bench wires a behavioural checker to chk_*)
//  - req0 mode0, A=(4,4) rA=0 -> valid at T+193, candidate=1, resp_id=0.
//  - req0 mode0, A=(4,4) rA=1 -> candidate=5.
//  - mode1 and mode2, A=(4,4,1) B=(5,4,1) -> mode1: candidate=2; mode2: candidate=6.
//  - mode3, A=B=C=(4,4,1) -> candidate=0.
//    Then A=B=(4,4,1), C=(8,8,0) -> candidate=5.
//  - req0 and req1 valid together after reset -> req0 served first, then req1.
//    resp_id sequence 0,1; busy=0 exactly one cycle (the IDLE cycle) between the jobs.
//  - rst pulse at cycle 100 of CHK -> busy=0 and no valid pulse.
//    A new job afterwards returns the correct count.

Source files
------------

// File: rtl/set_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : set_job_scheduler
// Purpose  : Round-robin shares one combinational point-in-circle checker
//            between two job requesters. Each job evaluates 64 grid points
//            (1..8 x 1..8) against three circles, counts the points that
//            satisfy the selected set mode and returns the tagged count.
// Ports    : clk, rst (async, active-high)
//            reqN_valid/ready/central/radius/mode  (N = 0,1) job requests
//            chk_x/y/r, chk_px/py -> shared checker;  chk_in <- its result
//            busy, valid, candidate, resp_id       job result
// Revision : 1.0  initial release
// ============================================================================
module set_job_scheduler #(
  parameter int GRID_LOG2 = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [23:0]      req0_central,
  input  logic [11:0]      req0_radius,
  input  logic [1:0]       req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [23:0]      req1_central,
  input  logic [11:0]      req1_radius,
  input  logic [1:0]       req1_mode,
  output logic [3:0]       chk_x,
  output logic [3:0]       chk_y,
  output logic [3:0]       chk_r,
  output logic [3:0]       chk_px,
  output logic [3:0]       chk_py,
  input  logic             chk_in,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] candidate,
  output logic             resp_id
);

  localparam int PW = 2 * GRID_LOG2;  // point index width
  localparam int CW = PW + 1;         // count width, holds 0..64

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CHK  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [23:0]   central_q;
  logic [11:0]   radius_q;
  logic [1:0]    mode_q;
  logic [PW-1:0] point;
  logic [1:0]    circ;
  logic          a_q, b_q;
  logic [CW-1:0] count, count_nxt;
  logic          id, last_id;
  logic          grant0, grant1, hit, last_step;

  // A lone requester always wins; on a tie the one not served last wins.
  assign grant0 = req0_valid && (!req1_valid || last_id);
  assign grant1 = req1_valid && (!req0_valid || !last_id);

  assign last_step = (point == {PW{1'b1}}) && (circ == 2'd2);

  // Set-mode qualifier, evaluated on the circle C cycle with chk_in as C.
  always_comb begin
    hit = 1'b0;
    case (mode_q)
      2'd0:    hit = a_q;
      2'd1:    hit = a_q & b_q;
      2'd2:    hit = a_q ^ b_q;
      default: hit = (a_q & b_q & ~chk_in) | (a_q & ~b_q & chk_in) |
                     (~a_q & b_q & chk_in);
    endcase
  end

  assign count_nxt = count + CW'(hit);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant0 || grant1) state_nxt = S_CHK;
      S_CHK:   if (last_step)        state_nxt = S_DONE;
      S_DONE:                        state_nxt = S_IDLE;
      default:                       state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready = (state == S_IDLE) && grant0;
    req1_ready = (state == S_IDLE) && grant1;
    busy       = (state == S_CHK) || (state == S_DONE);
    valid      = (state == S_DONE);
    chk_x      = 4'd0;
    chk_y      = 4'd0;
    chk_r      = 4'd0;
    chk_px     = 4'd0;
    chk_py     = 4'd0;
    if (state == S_CHK) begin
      chk_px = 4'(point[PW-1:GRID_LOG2]) + 4'd1;
      chk_py = 4'(point[GRID_LOG2-1:0]) + 4'd1;
      case (circ)
        2'd0: begin
          chk_x = central_q[23:20];
          chk_y = central_q[19:16];
          chk_r = radius_q[11:8];
        end
        2'd1: begin
          chk_x = central_q[15:12];
          chk_y = central_q[11:8];
          chk_r = radius_q[7:4];
        end
        2'd2: begin
          chk_x = central_q[7:4];
          chk_y = central_q[3:0];
          chk_r = radius_q[3:0];
        end
        default: ;
      endcase
    end
  end

  // Job datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      point     <= '0;
      circ      <= '0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      count     <= '0;
      id        <= 1'b0;
      last_id   <= 1'b1;
      candidate <= '0;
      resp_id   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant0 || grant1) begin
            central_q <= grant1 ? req1_central : req0_central;
            radius_q  <= grant1 ? req1_radius  : req0_radius;
            mode_q    <= grant1 ? req1_mode    : req0_mode;
            id        <= grant1;
            last_id   <= grant1;
            point     <= '0;
            circ      <= '0;
            count     <= '0;
          end
        end
        S_CHK: begin
          case (circ)
            2'd0: begin
              a_q  <= chk_in;
              circ <= 2'd1;
            end
            2'd1: begin
              b_q  <= chk_in;
              circ <= 2'd2;
            end
            default: begin
              count <= count_nxt;
              circ  <= 2'd0;
              point <= point + PW'(1);
              // Result registers load as DONE is entered so they are
              // valid during the DONE cycle and hold afterwards.
              if (last_step) begin
                candidate <= CNT_W'(count_nxt);
                resp_id   <= id;
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_set_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_set_job_scheduler
// Purpose  : Directed self-checking bench for set_job_scheduler with a
//            behavioural point-in-circle checker on the chk_* port.
// Revision : 1.0  initial release
// ============================================================================
module tb_set_job_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [23:0] req0_central, req1_central;
  logic [11:0] req0_radius, req1_radius;
  logic [1:0]  req0_mode, req1_mode;
  logic [3:0]  chk_x, chk_y, chk_r, chk_px, chk_py;
  logic        chk_in;
  logic        busy, valid, resp_id;
  logic [7:0]  candidate;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  set_job_scheduler #(.GRID_LOG2(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_central(req0_central), .req0_radius(req0_radius), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_central(req1_central), .req1_radius(req1_radius), .req1_mode(req1_mode),
    .chk_x(chk_x), .chk_y(chk_y), .chk_r(chk_r), .chk_px(chk_px), .chk_py(chk_py),
    .chk_in(chk_in), .busy(busy), .valid(valid), .candidate(candidate),
    .resp_id(resp_id)
  );

  function automatic logic in_circle(input logic [3:0] x, y, r, px, py);
    int dx, dy;
    dx = int'(x) - int'(px);
    dy = int'(y) - int'(py);
    return (dx * dx + dy * dy) <= (int'(r) * int'(r));
  endfunction

  always_comb chk_in = in_circle(chk_x, chk_y, chk_r, chk_px, chk_py);

  function automatic logic [23:0] cen(input logic [3:0] xa, ya, xb, yb, xc, yc);
    return {xa, ya, xb, yb, xc, yc};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) until valid is seen, sampling #1 after each edge.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Entered #1 after an edge with the DUT idle; runs one job on requester n.
  task automatic run_job(input string tag, input int n, input logic [23:0] c,
                         input logic [11:0] r, input logic [1:0] m, input int exp_cnt);
    int cyc;
    if (n == 0) begin
      req0_central = c; req0_radius = r; req0_mode = m; req0_valid = 1'b1;
    end else begin
      req1_central = c; req1_radius = r; req1_mode = m; req1_valid = 1'b1;
    end
    #1;
    check({tag, " ready"}, (n == 0) ? req0_ready : req1_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_central = '0;
    req1_central = '0;
    check({tag, " busy"}, busy, 1);
    check({tag, " first chk_x"}, chk_x, c[23:20]);
    check({tag, " first chk_r"}, chk_r, r[11:8]);
    check({tag, " first px/py"}, {chk_px, chk_py}, 8'h11);
    wait_valid(cyc);
    check({tag, " latency"}, cyc, 192);
    check({tag, " candidate"}, candidate, exp_cnt);
    check({tag, " resp_id"}, resp_id, n);
    @(posedge clk); #1;
    check({tag, " valid pulse"}, valid, 0);
    check({tag, " candidate hold"}, candidate, exp_cnt);
    check({tag, " idle chk_x"}, chk_x, 0);
  endtask

  initial begin
    int cyc;
    int pulses;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_central = '0; req1_central = '0;
    req0_radius = '0;  req1_radius = '0;
    req0_mode = '0;    req1_mode = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst valid", valid, 0);
    check("rst candidate", candidate, 0);
    check("rst resp_id", resp_id, 0);
    check("rst ready", {req0_ready, req1_ready}, 0);
    check("rst chk", {chk_x, chk_y, chk_r, chk_px, chk_py}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single-circle counts, then the two-circle and three-circle modes.
    run_job("m0 r0", 0, cen(4, 4, 0, 0, 0, 0), 12'h000, 2'd0, 1);
    run_job("m0 r1", 0, cen(4, 4, 0, 0, 0, 0), 12'h100, 2'd0, 5);
    run_job("m1", 0, cen(4, 4, 5, 4, 0, 0), 12'h110, 2'd1, 2);
    run_job("m2 req1", 1, cen(4, 4, 5, 4, 0, 0), 12'h110, 2'd2, 6);
    run_job("m3 same", 1, cen(4, 4, 4, 4, 4, 4), 12'h111, 2'd3, 0);
    run_job("m3 C off", 0, cen(4, 4, 4, 4, 8, 8), 12'h110, 2'd3, 5);
    run_job("m0 full", 0, cen(4, 4, 0, 0, 0, 0), 12'hF00, 2'd0, 64);

    // Simultaneous requests after reset: req0 first, then req1.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    req0_central = cen(4, 4, 0, 0, 0, 0); req0_radius = 12'h000; req0_mode = 2'd0;
    req1_central = cen(4, 4, 0, 0, 0, 0); req1_radius = 12'h100; req1_mode = 2'd0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("tie grant", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_valid(cyc);
    check("tie first latency", cyc, 192);
    check("tie first id", resp_id, 0);
    check("tie first cand", candidate, 1);
    check("tie done ready1", req1_ready, 0);
    @(posedge clk); #1;
    check("tie gap busy", busy, 0);
    check("tie gap ready1", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    check("tie second busy", busy, 1);
    wait_valid(cyc);
    check("tie second latency", cyc, 192);
    check("tie second id", resp_id, 1);
    check("tie second cand", candidate, 5);
    @(posedge clk); #1;

    // Reset during CHK aborts the job without a result.
    req0_central = cen(4, 4, 0, 0, 0, 0); req0_radius = 12'h100; req0_mode = 2'd0;
    req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (99) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort candidate", candidate, 0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 250; i++) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    check("abort no valid", pulses, 0);
    check("abort idle busy", busy, 0);
    run_job("after abort", 0, cen(4, 4, 5, 4, 0, 0), 12'h110, 2'd2, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
